// File: rtl/trap_sequencer.sv
// Trap sequencer: captures exceptions/interrupts, drains the pipe,
// strobes the CSR context switch and redirects fetch to the trap vector.
module trap_sequencer #(
  parameter int DRAIN_MAX = 15
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IRQ_EXT,
  input  logic        IRQ_SW,
  input  logic        IRQ_TMR,
  input  logic [2:0]  IRQ_EN,
  input  logic        GIE,
  input  logic        EXC_VALID,
  input  logic [4:0]  EXC_CODE,
  input  logic [63:0] EXC_PC,
  input  logic [63:0] PC_NEXT,
  input  logic        PIPE_IDLE,
  input  logic        REDIR_ACK,
  output logic        STALL,
  output logic        CS,
  output logic [63:0] CAUSE,
  output logic [63:0] NPC,
  output logic        REDIR_VALID,
  output logic        BUSY,
  output logic [15:0] TRAP_CNT
);

  localparam int CW = (DRAIN_MAX < 1) ? 1 : $clog2(DRAIN_MAX + 1);
  localparam logic [CW-1:0] DMAX = CW'(DRAIN_MAX);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    SAVE,
    REDIRECT
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] drain_cnt;
  logic          is_exc;
  logic [15:0]   trap_cnt;
  logic [2:0]    irq_act;
  logic [4:0]    irq_code;
  logic          capture;

  assign irq_act = {IRQ_EXT, IRQ_SW, IRQ_TMR} & IRQ_EN;
  assign capture = EXC_VALID || (GIE && (|irq_act));

  // Fixed priority among interrupts: EXT > SW > TMR
  always_comb begin
    irq_code = 5'd0;
    if (irq_act[2])      irq_code = 5'd11;
    else if (irq_act[1]) irq_code = 5'd3;
    else if (irq_act[0]) irq_code = 5'd7;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (capture) state_nx = DRAIN;
      DRAIN:    if (PIPE_IDLE || drain_cnt == DMAX) state_nx = SAVE;
      SAVE:     state_nx = REDIRECT;
      REDIRECT: if (REDIR_ACK) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      CAUSE     <= 64'd0;
      NPC       <= 64'd0;
      is_exc    <= 1'b0;
      drain_cnt <= '0;
      trap_cnt  <= 16'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (capture) begin
            is_exc    <= EXC_VALID;
            drain_cnt <= '0;
            if (EXC_VALID) begin
              CAUSE <= {59'd0, EXC_CODE};
              NPC   <= EXC_PC;
            end else begin
              CAUSE <= {1'b1, 58'd0, irq_code};
              NPC   <= PC_NEXT;
            end
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + CW'(1);
          // A late exception overrides an interrupt; the first exception wins
          if (EXC_VALID && !is_exc) begin
            is_exc <= 1'b1;
            CAUSE  <= {59'd0, EXC_CODE};
            NPC    <= EXC_PC;
          end
        end
        SAVE:     trap_cnt <= trap_cnt + 16'd1;
        REDIRECT: ;
        default:  ;
      endcase
    end
  end

  assign BUSY        = (state != IDLE);
  assign STALL       = (state != IDLE);
  assign CS          = (state == SAVE);
  assign REDIR_VALID = (state == REDIRECT);
  assign TRAP_CNT    = trap_cnt;

endmodule
